// File: rtl/fetch_pkg.sv
// Shared core definitions for the instruction-fetch stage: NOP word, default
// reset PC, fetch FSM encoding, PC increment and the IF/ID payload struct.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: load a fetched word, flush to a NOP bubble
// (pc/pc4 hold), or hold everything when neither control is raised.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  ifid_t din,
  output ifid_t dout,
  output logic  valid
);

  ifid_t data_q, data_d;
  logic  valid_q, valid_d;

  // next IF/ID contents; load wins over flush
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (flush) begin
      data_d.inst = NOP_INST;
      valid_d     = 1'b0;
    end
  end

  // IF/ID storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch request, redirect/stall handling and the
// IF/ID register. Optional branch delay slot under FETCH_DELAY_SLOT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        accept, ld, fl;
  logic [31:0] tgt_in;
  ifid_t       fetched, ifid;

  assign tgt_in  = {redirect_pc[31:2], 2'b00};
  assign accept  = req_q & imem_ready & ~stall;
  assign req_d   = 1'b1;
  assign fetched = {imem_rdata, pc_q, pc_q + PC_INC};

`ifdef FETCH_DELAY_SLOT_EN
  fetch_state_e state_q, state_d;
  logic [31:0]  tgt_q, tgt_d;

  // delay-slot control: the word at PC is always delivered before the jump
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    ld      = 1'b0;
    fl      = 1'b0;
    if (state_q == ST_PEND) begin
      // waiting for the delay slot; further redirects are ignored
      if (accept) begin
        ld      = 1'b1;
        pc_d    = tgt_q;
        state_d = ST_RUN;
      end else if (!stall) begin
        fl = 1'b1;
      end
    end else if (redirect) begin
      if (accept) begin
        ld   = 1'b1;
        pc_d = tgt_in;
      end else begin
        tgt_d   = tgt_in;
        state_d = ST_PEND;
        fl      = ~stall;
      end
    end else if (accept) begin
      ld   = 1'b1;
      pc_d = pc_q + PC_INC;
    end else if (!stall) begin
      fl = 1'b1;
    end
  end

  // FSM state and latched redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end
`else
  // flush control: redirect beats stall and memory readiness
  always_comb begin
    pc_d = pc_q;
    ld   = 1'b0;
    fl   = 1'b0;
    if (redirect) begin
      pc_d = tgt_in;
      fl   = 1'b1;
    end else if (accept) begin
      ld   = 1'b1;
      pc_d = pc_q + PC_INC;
    end else if (!stall) begin
      fl = 1'b1;
    end
  end
`endif

  // program counter and fetch request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      req_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      req_q <= req_d;
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ld),
    .flush (fl),
    .din   (fetched),
    .dout  (ifid),
    .valid (id_valid)
  );

  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign id_inst   = ifid.inst;
  assign id_pc     = ifid.pc;
  assign id_pc4    = ifid.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked by a
// scoreboard fed from an instruction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic        imem_req, imem_ready, stall, redirect;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        id_valid;

  typedef struct packed {
    logic [31:0] addr;
    logic        req;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        vld;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // architectural view of the fetch stage
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_tgt;
  logic        m_req, m_vld, m_pend;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = imem_ready ? memf(imem_addr) : 32'hDEAD_BEEF;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: one step per rising edge, expected outputs to scoreboard
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pc = RST_PC; m_req = 1'b0; m_inst = '0; m_ipc = '0; m_ipc4 = '0;
      m_vld = 1'b0; m_pend = 1'b0; m_tgt = '0;
    end else begin
      logic acc, dlv, bub;
      logic [31:0] nxt, tgt;
      acc = m_req && imem_ready && !stall;
      tgt = redirect_pc & ~32'd3;
      dlv = 1'b0; bub = 1'b0; nxt = m_pc;
`ifdef FETCH_DELAY_SLOT_EN
      if (m_pend) begin
        if (acc) begin dlv = 1'b1; nxt = m_tgt; m_pend = 1'b0; end
        else bub = !stall;
      end else if (redirect) begin
        if (acc) begin dlv = 1'b1; nxt = tgt; end
        else begin m_tgt = tgt; m_pend = 1'b1; bub = !stall; end
      end else if (acc) begin dlv = 1'b1; nxt = m_pc + 32'd4; end
      else bub = !stall;
`else
      if (redirect) begin bub = 1'b1; nxt = tgt; end
      else if (acc) begin dlv = 1'b1; nxt = m_pc + 32'd4; end
      else bub = !stall;
`endif
      if (dlv) begin
        m_inst = memf(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_vld = 1'b1;
      end else if (bub) begin
        m_inst = 32'h0; m_vld = 1'b0;
      end
      m_pc  = nxt;
      m_req = 1'b1;
      exp_q.push_back('{addr: m_pc, req: m_req, inst: m_inst, pc: m_ipc, pc4: m_ipc4, vld: m_vld});
    end
  end

  // monitor: compare DUT against the oldest expected entry after each edge
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      #1;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        chk("fetch_addr_req", {95'b0, imem_addr, imem_req}, {95'b0, e.addr, e.req});
        chk("id_inst_valid", {95'b0, id_inst, id_valid}, {95'b0, e.inst, e.vld});
        if (e.vld) chk("id_pc_pc4", {64'b0, id_pc, id_pc4}, {64'b0, e.pc, e.pc4});
      end
    end
  end

  // drive one cycle's inputs at a falling edge, advance to the next one
  task automatic cyc(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
    imem_ready = rdy; stall = stl; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // assert reset asynchronously and check reset values immediately
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_addr_req", {95'b0, imem_addr, imem_req}, {95'b0, RST_PC, 1'b0});
    chk("rst_id", {31'b0, id_inst, id_pc, id_pc4, id_valid}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    do_reset();
    repeat (4) cyc(1, 0, 0, 0);
    // stall at PC 0x10
    cyc(1, 0, 1, 32'h10);
    repeat (3) cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    // memory wait states
    repeat (2) cyc(0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    // redirect at PC 0x20, then redirect under stall
    cyc(1, 0, 1, 32'h20);
    cyc(1, 0, 1, 32'h0000_0203);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h0000_0203);
    repeat (2) cyc(1, 0, 0, 0);
    // PC wrap at the top of the address space
    cyc(1, 0, 1, 32'hFFFF_FFF8);
    repeat (4) cyc(1, 0, 0, 0);
    // redirect to the current PC refetches it
    cyc(1, 0, 1, 32'h300);
    cyc(1, 0, 1, 32'h300);
    repeat (2) cyc(1, 0, 0, 0);
`ifdef FETCH_DELAY_SLOT_EN
    cyc(1, 0, 1, 32'h24);
    cyc(0, 0, 1, 32'h400);
    cyc(0, 0, 1, 32'h800);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h500);
    cyc(0, 0, 0, 0);
`else
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
`endif
    // reset in the middle of a stall / pending redirect
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : {20'h0, 12'($urandom_range(0, 4095))};
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
          $urandom_range(0, 9) == 0, rpc);
      if (i == 200) do_reset();
    end
    repeat (3) cyc(1, 0, 0, 0);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
